// File: rtl/hamming_pkg.sv
// Shared widths and types for the Hamming byte packer, encoder and decoder.
package hamming_pkg;

    localparam int DATA_W = 16;
    localparam int BYTE_W = 8;
    localparam int PAR_W  = 5;
    localparam int CODE_W = 21;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [BYTE_W-1:0] byte_t;
    typedef logic [CODE_W-1:0] code_t;

endpackage

// File: rtl/hamming_sync_fifo.sv
// Synchronous word FIFO: a push is visible at the head one cycle later; pushes are dropped when full.
// spaceReady is registered from the next-cycle level, so it never depends combinationally on pop.
module hamming_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         pushData,
    input  logic                     pop,
    output logic [WIDTH-1:0]         headData,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty,
    output logic                     spaceReady
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FullLevel = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic [AW:0]      levelNext;
    logic             doPush;
    logic             doPop;

    assign full     = (level == FullLevel);
    assign empty    = (level == '0);
    assign doPush   = push & ~full;
    assign doPop    = pop & ~empty;
    assign headData = mem[rdPtr];

    always_comb begin
        levelNext = level;
        if (doPush && !doPop) begin
            levelNext = level + 1'b1;
        end else if (!doPush && doPop) begin
            levelNext = level - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr      <= '0;
            rdPtr      <= '0;
            level      <= '0;
            spaceReady <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (doPush) begin
                mem[wrPtr] <= pushData;
                wrPtr      <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            level      <= levelNext;
            spaceReady <= (levelNext < FullLevel);
        end
    end

endmodule

// File: rtl/hamming_byte_packer.sv
// Pairs bytes into 16-bit words (first byte high) and buffers them for the encoder; word visible
// one cycle after the completing edge. oReady is registered and drops while the FIFO is full.
module hamming_byte_packer
    import hamming_pkg::*;
#(
    parameter int    DEPTH = 4,
    parameter byte_t PAD   = 8'h00
) (
    input  logic                   clk,
    input  logic                   rst,
    input  byte_t                  iData,
    input  logic                   iValid,
    output logic                   oReady,
    input  logic                   iFlush,
    output data_t                  oData,
    output logic                   oValid,
    input  logic                   iReady,
    output logic [$clog2(DEPTH):0] oLevel,
    output logic [15:0]            oWordCnt
);

    byte_t hold;
    logic  half;
    logic  byteAcc;
    logic  flushTake;
    logic  push;
    data_t pushData;
    logic  pop;
    logic  fifoFull;
    logic  fifoEmpty;
    logic  [15:0] wordCnt;

    assign byteAcc = iValid & oReady;
    // A byte arriving with a flush request completes the pair itself, so the pad is not needed.
    assign flushTake = iFlush & half & ~byteAcc & ~fifoFull;
    assign push      = (byteAcc & half) | flushTake;
    assign pushData  = flushTake ? {hold, PAD} : {hold, iData};
    assign pop       = oValid & iReady;
    assign oValid    = ~fifoEmpty;
    assign oWordCnt  = wordCnt;

    hamming_sync_fifo #(
        .WIDTH(DATA_W),
        .DEPTH(DEPTH)
    ) uFifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pushData   (pushData),
        .pop        (pop),
        .headData   (oData),
        .level      (oLevel),
        .full       (fifoFull),
        .empty      (fifoEmpty),
        .spaceReady (oReady)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold    <= '0;
            half    <= 1'b0;
            wordCnt <= '0;
        end else begin
            if (byteAcc) begin
                if (!half) begin
                    hold <= iData;
                end
                half <= ~half;
            end else if (flushTake) begin
                half <= 1'b0;
            end
            if (pop) begin
                wordCnt <= wordCnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_hamming_byte_packer.sv
// Directed bench for hamming_byte_packer: packing, flush, full/backpressure, reset and counter wrap.
module tb_hamming_byte_packer;

    logic        clk;
    logic        rst;
    logic [7:0]  iData;
    logic        iValid;
    logic        oReady;
    logic        iFlush;
    logic [15:0] oData;
    logic        oValid;
    logic        iReady;
    logic [2:0]  oLevel;
    logic [15:0] oWordCnt;

    int checks = 0;
    int errors = 0;

    hamming_byte_packer #(.DEPTH(4), .PAD(8'h00)) dut (
        .clk      (clk),
        .rst      (rst),
        .iData    (iData),
        .iValid   (iValid),
        .oReady   (oReady),
        .iFlush   (iFlush),
        .oData    (oData),
        .oValid   (oValid),
        .iReady   (iReady),
        .oLevel   (oLevel),
        .oWordCnt (oWordCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for oReady, then presents one byte for exactly one edge.
    task automatic sendByte(input logic [7:0] b);
        int n;
        n = 0;
        while (!oReady && n < 20) begin
            tick();
            n++;
        end
        checkVal("byte_ready", 32'(oReady), 32'd1);
        iValid = 1'b1;
        iData  = b;
        tick();
        iValid = 1'b0;
    endtask

    task automatic checkIdle(input string tag);
        checkVal({tag, "_valid"}, 32'(oValid), 32'd0);
        checkVal({tag, "_data"},  32'(oData),  32'd0);
        checkVal({tag, "_ready"}, 32'(oReady), 32'd0);
        checkVal({tag, "_level"}, 32'(oLevel), 32'd0);
        checkVal({tag, "_cnt"},   32'(oWordCnt), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        int seen;
        rst    = 1'b0;
        iData  = 8'h00;
        iValid = 1'b0;
        iFlush = 1'b0;
        iReady = 1'b0;

        // Reset held for three cycles
        repeat (3) tick();
        checkIdle("reset");
        rst = 1'b1;
        tick();
        checkVal("ready_after_reset", 32'(oReady), 32'd1);

        // Basic packing
        iReady = 1'b1;
        sendByte(8'hA5);
        checkVal("half_no_word", 32'(oValid), 32'd0);
        sendByte(8'h3C);
        checkVal("pack_valid", 32'(oValid), 32'd1);
        checkVal("pack_data", 32'(oData), 32'hA53C);
        tick();
        checkVal("pack_popped", 32'(oValid), 32'd0);
        checkVal("pack_cnt", 32'(oWordCnt), 32'd1);

        // Flush pads a lone byte
        iReady = 1'b0;
        sendByte(8'h7E);
        iFlush = 1'b1;
        tick();
        iFlush = 1'b0;
        checkVal("flush_valid", 32'(oValid), 32'd1);
        checkVal("flush_data", 32'(oData), 32'h7E00);
        checkVal("flush_level", 32'(oLevel), 32'd1);
        iReady = 1'b1;
        tick();
        iReady = 1'b0;
        checkVal("flush_cnt", 32'(oWordCnt), 32'd2);

        // Flush colliding with a byte: the byte completes the pair
        sendByte(8'h7E);
        iFlush = 1'b1;
        sendByte(8'h99);
        tick();
        iFlush = 1'b0;
        checkVal("collide_level", 32'(oLevel), 32'd1);
        checkVal("collide_data", 32'(oData), 32'h7E99);
        iReady = 1'b1;
        tick();
        iReady = 1'b0;
        checkVal("collide_cnt", 32'(oWordCnt), 32'd3);
        checkVal("collide_empty", 32'(oLevel), 32'd0);

        // Fill the FIFO under backpressure
        for (int b = 1; b <= 8; b++) begin
            sendByte(8'(b));
        end
        checkVal("full_level", 32'(oLevel), 32'd4);
        checkVal("full_ready", 32'(oReady), 32'd0);
        checkVal("full_head", 32'(oData), 32'h0102);
        iValid = 1'b1;
        iData  = 8'h09;
        tick();
        tick();
        iValid = 1'b0;
        checkVal("ninth_level", 32'(oLevel), 32'd4);
        checkVal("stall_data", 32'(oData), 32'h0102);
        checkVal("stall_valid", 32'(oValid), 32'd1);
        iReady = 1'b1;
        tick();
        checkVal("drain_1", 32'(oData), 32'h0304);
        checkVal("ready_reraised", 32'(oReady), 32'd1);
        tick();
        checkVal("drain_2", 32'(oData), 32'h0506);
        tick();
        checkVal("drain_3", 32'(oData), 32'h0708);
        tick();
        checkVal("drain_empty", 32'(oValid), 32'd0);
        checkVal("drain_cnt", 32'(oWordCnt), 32'd7);
        // The rejected ninth byte must not have been captured
        sendByte(8'hAA);
        sendByte(8'hBB);
        checkVal("after_full_data", 32'(oData), 32'hAABB);
        tick();
        checkVal("after_full_cnt", 32'(oWordCnt), 32'd8);

        // Reset with three words and a half byte pending
        iReady = 1'b0;
        for (int b = 8'h11; b <= 8'h17; b++) begin
            sendByte(8'(b));
        end
        checkVal("pre_rst_level", 32'(oLevel), 32'd3);
        rst = 1'b0;
        #1;
        checkIdle("mid_reset");
        tick();
        tick();
        rst    = 1'b1;
        iReady = 1'b1;
        seen   = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (oValid) seen++;
        end
        checkVal("no_stale_word", 32'(seen), 32'd0);
        sendByte(8'h21);
        sendByte(8'h22);
        checkVal("post_rst_data", 32'(oData), 32'h2122);
        tick();
        checkVal("post_rst_cnt", 32'(oWordCnt), 32'd1);

        // Counter wrap: preload near the top, then deliver words
        force dut.wordCnt = 16'hFFFE;
        #1;
        release dut.wordCnt;
        sendByte(8'hC1);
        sendByte(8'hC2);
        checkVal("wrap_data_1", 32'(oData), 32'hC1C2);
        tick();
        checkVal("cnt_ffff", 32'(oWordCnt), 32'hFFFF);
        sendByte(8'hC3);
        sendByte(8'hC4);
        checkVal("wrap_data_2", 32'(oData), 32'hC3C4);
        tick();
        checkVal("cnt_wrap", 32'(oWordCnt), 32'h0000);
        sendByte(8'hC5);
        sendByte(8'hC6);
        checkVal("wrap_data_3", 32'(oData), 32'hC5C6);
        tick();
        checkVal("cnt_after_wrap", 32'(oWordCnt), 32'h0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hamming_byte_packer.md
Name: hamming_byte_packer

Overview:
Upstream source stage for the Hamming encoder. Accepts an 8-bit byte stream with a valid/ready handshake and packs byte pairs into 16-bit words. Buffers the words in a small synchronous FIFO and presents them to the encoder's 16-bit data input with a valid/ready handshake. A flush input pads a trailing odd byte so no data is stranded.

Parameters:
DEPTH, 4, FIFO depth in 16-bit words; power of two, >= 2.
PAD, 8'h00, low byte inserted when a lone high byte is flushed.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-low
iData  input  8  input byte
iValid  input  1  input byte valid
oReady  output  1  packer can accept a byte (registered)
iFlush  input  1  level request to emit a pending odd byte padded with PAD
oData  output  16  word to encoder, first byte in [15:8], second in [7:0]
oValid  output  1  oData valid
iReady  input  1  encoder accepts word
oLevel  output  $clog2(DEPTH)+1  words currently in FIFO
oWordCnt  output  16  words delivered, wraps modulo 2^16

Behaviour:
- Reset (rst=0, async): FIFO empty, pointers 0, storage cleared to 0, half=0, hold=0.
  - Outputs during reset: oValid=0, oData=16'h0000, oReady=0, oLevel=0, oWordCnt=0.
  - oReady rises in the first clock edge after rst deasserts.
  - Reset mid-operation discards all buffered bytes and words; nothing is delivered afterwards.
- Byte accept: iValid & oReady at a rising edge.
  - half=0: byte goes to hold; half becomes 1.
  - half=1: word {hold, iData} is pushed to the FIFO; half becomes 0.
- Flush: acts in a cycle where iFlush=1, half=1, no byte accepted and FIFO not full.
  - Pushes {hold, PAD}; half becomes 0.
  - When a byte is accepted in the same cycle, the byte wins and the flush is not taken; iFlush must stay high to be taken later.
  - iFlush with half=0 has no effect.
  - When the FIFO is full, the flush waits until space frees.
- oReady register: next value = (next level < DEPTH). It does not depend combinationally on iReady.
  - A pop in the cycle the FIFO fills re-raises oReady one cycle later.
- Output side:
  - oValid = level != 0.
  - oData = head word, held stable while oValid & !iReady.
  - Word transfer on oValid & iReady; FIFO pops.
- Latency: the word from a completed byte pair or flush appears with oValid=1 in the cycle after the completing edge, when the FIFO was empty.
- Simultaneous push and pop: level unchanged, both take effect. Pop from a level-1 FIFO with a push in the same cycle keeps oValid=1 with the new word.
- Full: level=DEPTH. oReady=0 and no push occurs. The half/hold state is retained.
- Pointer arithmetic: $clog2(DEPTH) bits, natural wrap; level is tracked with an extra bit.
- oWordCnt increments on each output transfer; 16'hFFFF wraps to 16'h0000.

Decomposition:
- Shared package hamming_pkg holds:
  - constants DATA_W=16, BYTE_W=8, PAR_W=5, CODE_W=21;
  - typedefs data_t (16-bit), byte_t (8-bit), code_t (21-bit).
- The encoder, decoder and this block all import it.
- Sub-module hamming_sync_fifo is parameterised by width and depth: push/pop, level, registered-ready helper. The packer adds the byte-pairing, hold register and flush logic around it.

Test Plan:
- Reset behaviour: hold rst=0 for 3 cycles -> oValid=0, oData=16'h0000, oReady=0, oLevel=0. Release rst -> oReady=1 on the next edge.
- Basic packing: bytes 8'hA5, 8'h3C with iReady=1 -> one word 16'hA53C with oValid for one cycle, one cycle after the second byte; oWordCnt=1.
- Flush: byte 8'h7E then iFlush=1 -> word 16'h7E00 (PAD=8'h00). A flush-plus-byte collision instead yields {7E, byte} with no pad.
- Backpressure and full: iReady=0, stream 8 bytes 8'h01..8'h08 with DEPTH=4 -> oLevel=4, oReady=0. A 9th byte is not accepted. Raising iReady -> words 0102, 0304, 0506, 0708 in order, oData stable while stalled.
- Mid-operation reset: assert rst with oLevel=3 and half=1 -> all outputs return to reset values. No stale word appears after release.
- Counter wrap: preload by delivering 65536 words -> oWordCnt reads 16'h0000. Data is unaffected.
